// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with internal pixel-rate clock enable
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CLK_DIV  = 4,
   parameter int CW       = 10,
   parameter int FCW      = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   output logic           pix_tick,
   output logic [CW-1:0]  pixel_x,
   output logic [CW-1:0]  pixel_y,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic           line_start,
   output logic           frame_start,
   output logic [FCW-1:0] frame_count
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
   // region bounds are one bit wider so an end bound equal to the total cannot wrap
   localparam logic [CW:0] X_ACT  = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0] Y_ACT  = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   logic [DW-1:0]  div_q, div_d;
   logic [CW-1:0]  x_q, x_d, y_q, y_d;
   logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic           tick_q, tick_d, ls_q, ls_d, fs_q, fs_d;
   logic [FCW-1:0] fc_q, fc_d;
   logic           adv;
   logic [CW:0]    xw, yw;

   assign adv = enable && (div_q == DIV_LAST);
   assign xw  = {1'b0, x_d};
   assign yw  = {1'b0, y_d};

   // divider and raster counters: advance once per divider wrap, hold while paused
   always_comb begin
      div_d = div_q;
      x_d   = x_q;
      y_d   = y_q;
      if (enable)
         div_d = adv ? '0 : div_q + 1'b1;
      if (adv) begin
         x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
         y_d = (x_q != X_LAST) ? y_q : (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end
   end

   // sync/de decoded from the next coordinates so they line up with pixel_x/pixel_y
   always_comb begin
      hs_d   = adv ? (((xw >= HS_BEG) && (xw < HS_END)) ? HS_ON : !HS_ON) : hs_q;
      vs_d   = adv ? (((yw >= VS_BEG) && (yw < VS_END)) ? VS_ON : !VS_ON) : vs_q;
      de_d   = adv ? ((xw < X_ACT) && (yw < Y_ACT)) : de_q;
      tick_d = adv;
      ls_d   = adv && (x_d == '0);
      fs_d   = adv && (x_d == '0) && (y_d == '0);
      fc_d   = fs_d ? fc_q + 1'b1 : fc_q;
   end

   // state registers; reset parks the raster on the last pixel so the first advance lands on (0,0)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= '0;
         x_q    <= X_LAST;
         y_q    <= Y_LAST;
         hs_q   <= !HS_ON;
         vs_q   <= !VS_ON;
         de_q   <= 1'b0;
         tick_q <= 1'b0;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
         fc_q   <= '1;
      end else begin
         div_q  <= div_d;
         x_q    <= x_d;
         y_q    <= y_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         de_q   <= de_d;
         tick_q <= tick_d;
         ls_q   <= ls_d;
         fs_q   <= fs_d;
         fc_q   <= fc_d;
      end
   end

   assign pix_tick    = tick_q;
   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign de          = de_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_count = fc_q;
endmodule
